fp_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational single-precision float multiplier among `NREQ` requesters. Each requester hands over an operand pair with a valid/ready handshake. The block registers the operands, evaluates the multiplier for one cycle and registers the result and flags. It then returns them to the granted requester over a per-requester response handshake. It sits between the compute clients and the multiplier core so that only one multiplier instance is needed.

---
 rtl/fp_mul_arb_pkg.sv | 20 ++
 rtl/fp_mul_arbiter_mult.sv | 50 +++++
 rtl/fp_mul_arbiter.sv | 152 +++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_arb_pkg.sv
// Shared types and constants for the round-robin float multiplier arbiter.
package fp_mul_arb_pkg;

   localparam int FP_W = 32;
   localparam logic [7:0] FP_EXP_MAX = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arbState_e;

   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/fp_mul_arbiter_mult.sv
// Combinational single-precision multiplier core: truncating, denormal inputs treated as zero,
// exception on any Inf/NaN operand, saturating overflow to Inf and underflow to zero.
module floatMultiplier
   import fp_mul_arb_pkg::*;
(
   input  logic [FP_W-1:0] a_i,
   input  logic [FP_W-1:0] b_i,
   output logic [FP_W-1:0] result_o,
   output logic            exception_o,
   output logic            overflow_o,
   output logic            underflow_o
);

   logic        signR;
   logic [7:0]  expA;
   logic [7:0]  expB;
   logic [47:0] prod;
   logic [10:0] expSum;
   logic [22:0] mant;

   always_comb begin
      signR  = a_i[31] ^ b_i[31];
      expA   = a_i[30:23];
      expB   = b_i[30:23];
      prod   = {24'b0, 1'b1, a_i[22:0]} * {24'b0, 1'b1, b_i[22:0]};
      // Biased sum kept in 11 bits so a negative exponent shows up as bit 10 set.
      expSum = {3'b0, expA} + {3'b0, expB} + {10'b0, prod[47]} - 11'd127;
      mant   = prod[47] ? prod[46:24] : prod[45:23];

      result_o    = '0;
      exception_o = 1'b0;
      overflow_o  = 1'b0;
      underflow_o = 1'b0;

      if (expA == FP_EXP_MAX || expB == FP_EXP_MAX) begin
         exception_o = 1'b1;
      end else if (expA == 8'd0 || expB == 8'd0) begin
         result_o = {signR, 31'b0};
      end else if (expSum[10] || expSum == 11'd0) begin
         underflow_o = 1'b1;
         result_o    = {signR, 31'b0};
      end else if (expSum >= 11'd255) begin
         overflow_o = 1'b1;
         result_o   = {signR, FP_EXP_MAX, 23'b0};
      end else begin
         result_o = {signR, expSum[7:0], mant};
      end
   end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one floatMultiplier among NREQ requesters (accept, execute, respond).
// Defining FP_MUL_ARB_CNT_EN adds op_count / exc_count response counters.
module fp_mul_arbiter
   import fp_mul_arb_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [FP_W*NREQ-1:0] req_a,
   input  logic [FP_W*NREQ-1:0] req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [FP_W-1:0]      rsp_result,
   output logic                 rsp_exception,
   output logic                 rsp_overflow,
   output logic                 rsp_underflow
`ifdef FP_MUL_ARB_CNT_EN
   ,
   output logic [31:0]          op_count,
   output logic [15:0]          exc_count
`endif
);

   localparam int GW = clog2(NREQ);

   arbState_e         state_q;
   logic [GW-1:0]     lastGrant_q;
   logic [GW-1:0]     grant_q;
   logic [FP_W-1:0]   opA_q;
   logic [FP_W-1:0]   opB_q;
   logic [FP_W-1:0]   result_q;
   logic              exc_q;
   logic              ovf_q;
   logic              unf_q;
   logic [NREQ-1:0]   rspValid_q;

   logic [GW-1:0]     grantIdx_d;
   logic              found;
   logic [FP_W-1:0]   opA_d;
   logic [FP_W-1:0]   opB_d;
   logic              accept;
   logic              rspHandshake;

   logic [FP_W-1:0]   mulResult;
   logic              mulExc;
   logic              mulOvf;
   logic              mulUnf;

   // Rotate the search to start just past the last served requester, then take the first valid one.
   always_comb begin
      grantIdx_d = lastGrant_q;
      found      = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = int'(lastGrant_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grantIdx_d = GW'(idx);
         end
      end

      req_ready = '0;
      if (state_q == IDLE && found && !rst) req_ready[grantIdx_d] = 1'b1;

      accept       = |(req_valid & req_ready);
      opA_d        = req_a[FP_W*grantIdx_d +: FP_W];
      opB_d        = req_b[FP_W*grantIdx_d +: FP_W];
      rspHandshake = (state_q == RESP) && rsp_ready[grant_q];
   end

   floatMultiplier uMult (
      .a_i         (opA_q),
      .b_i         (opB_q),
      .result_o    (mulResult),
      .exception_o (mulExc),
      .overflow_o  (mulOvf),
      .underflow_o (mulUnf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lastGrant_q <= GW'(NREQ - 1);
         grant_q     <= '0;
         opA_q       <= '0;
         opB_q       <= '0;
         result_q    <= '0;
         exc_q       <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         rspValid_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  opA_q   <= opA_d;
                  opB_q   <= opB_d;
                  grant_q <= grantIdx_d;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               result_q   <= mulResult;
               exc_q      <= mulExc;
               ovf_q      <= mulOvf;
               unf_q      <= mulUnf;
               rspValid_q <= {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
               state_q    <= RESP;
            end
            RESP: begin
               if (rspHandshake) begin
                  rspValid_q  <= '0;
                  lastGrant_q <= grant_q;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid     = rspValid_q;
   assign rsp_result    = result_q;
   assign rsp_exception = exc_q;
   assign rsp_overflow  = ovf_q;
   assign rsp_underflow = unf_q;

`ifdef FP_MUL_ARB_CNT_EN
   logic [31:0] opCount_q;
   logic [15:0] excCount_q;

   // Exception counter saturates so a stuck faulty client cannot make it look healthy again.
   always_ff @(posedge clk) begin
      if (rst) begin
         opCount_q  <= '0;
         excCount_q <= '0;
      end else if (rspHandshake) begin
         opCount_q <= opCount_q + 32'd1;
         if ((exc_q || ovf_q || unf_q) && excCount_q != 16'hFFFF)
            excCount_q <= excCount_q + 16'd1;
      end
   end

   assign op_count  = opCount_q;
   assign exc_count = excCount_q;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed self-checking bench for fp_mul_arbiter (NREQ = 4); counter checks follow FP_MUL_ARB_CNT_EN.
module tb_fp_mul_arbiter;

   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [32*NREQ-1:0] req_a;
   logic [32*NREQ-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [NREQ-1:0]   rsp_ready;
   logic [31:0]       rsp_result;
   logic              rsp_exception;
   logic              rsp_overflow;
   logic              rsp_underflow;
`ifdef FP_MUL_ARB_CNT_EN
   logic [31:0]       op_count;
   logic [15:0]       exc_count;
`endif

   int compared   = 0;
   int mismatched = 0;

   fp_mul_arbiter #(.NREQ(NREQ)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_result    (rsp_result),
      .rsp_exception (rsp_exception),
      .rsp_overflow  (rsp_overflow),
      .rsp_underflow (rsp_underflow)
`ifdef FP_MUL_ARB_CNT_EN
      ,
      .op_count      (op_count),
      .exc_count     (exc_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b);
      req_a[idx*32 +: 32] = a;
      req_b[idx*32 +: 32] = b;
      req_valid[idx]      = 1'b1;
   endtask

   // One complete operation with rsp_ready already high; starts and ends 1ns after an edge in IDLE.
   task automatic runOp(input string tag, input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expRes, input logic [2:0] expFlags);
      applyStimulus(idx, a, b);
      #1;
      checkOutput({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
      step();
      req_valid[idx] = 1'b0;
      step();
      checkOutput({tag, "_rspvalid"}, 32'(rsp_valid), 32'(1 << idx));
      checkOutput({tag, "_result"}, rsp_result, expRes);
      checkOutput({tag, "_flags"}, 32'({rsp_exception, rsp_overflow, rsp_underflow}), 32'(expFlags));
      step();
   endtask

   initial begin
      logic [31:0] rrA   [5];
      logic [31:0] rrB   [5];
      logic [31:0] rrExp [5];
      int          rrIdx [5];

      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '0;
      step();
      step();

      // Reset state, with a request already pending that must not be accepted yet.
      applyStimulus(0, 32'h40000000, 32'h40400000);
      #1;
      checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("rst_result", rsp_result, 32'h0);
      checkOutput("rst_flags", 32'({rsp_exception, rsp_overflow, rsp_underflow}), 32'h0);
      step();
      checkOutput("rst_no_accept", 32'(rsp_valid), 32'h0);

      rst = 1'b0;
      #1;
      checkOutput("t1_ready", 32'(req_ready), 32'h1);
      step();
      req_valid[0] = 1'b0;
      checkOutput("t1_exec_ready", 32'(req_ready), 32'h0);
      checkOutput("t1_exec_rspvalid", 32'(rsp_valid), 32'h0);
      step();
      checkOutput("t1_rspvalid", 32'(rsp_valid), 32'h1);
      checkOutput("t1_result", rsp_result, 32'h40C00000);
      checkOutput("t1_flags", 32'({rsp_exception, rsp_overflow, rsp_underflow}), 32'h0);
      rsp_ready = 4'b1111;
      step();
      checkOutput("t1_rspvalid_clr", 32'(rsp_valid), 32'h0);

      // Round robin from a fresh reset with all four requesters continuously valid.
      rst = 1'b1;
      step();
      rst = 1'b0;
      rrA[0] = 32'h3FC00000; rrB[0] = 32'h3FC00000; rrExp[0] = 32'h40100000; rrIdx[0] = 0;
      rrA[1] = 32'h40000000; rrB[1] = 32'h40400000; rrExp[1] = 32'h40C00000; rrIdx[1] = 1;
      rrA[2] = 32'h3F800000; rrB[2] = 32'hC0000000; rrExp[2] = 32'hC0000000; rrIdx[2] = 2;
      rrA[3] = 32'h40800000; rrB[3] = 32'h3F000000; rrExp[3] = 32'h40000000; rrIdx[3] = 3;
      rrA[4] = rrA[0];       rrB[4] = rrB[0];       rrExp[4] = rrExp[0];      rrIdx[4] = 0;
      for (int i = 0; i < 4; i++) applyStimulus(i, rrA[i], rrB[i]);
      #1;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("rr%0d_ready", i), 32'(req_ready), 32'(1 << rrIdx[i]));
         step();
         step();
         checkOutput($sformatf("rr%0d_rspvalid", i), 32'(rsp_valid), 32'(1 << rrIdx[i]));
         checkOutput($sformatf("rr%0d_result", i), rsp_result, rrExp[i]);
         step();
      end
      req_valid = '0;

      runOp("ovf", 0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
      runOp("unf", 0, 32'h00800000, 32'h00800000, 32'h00000000, 3'b001);
      runOp("exc", 0, 32'h7F800000, 32'h3F800000, 32'h00000000, 3'b100);

      // Backpressure on requester 1 while requester 2 waits; other rsp_ready bits must be ignored.
      rsp_ready = 4'b0000;
      applyStimulus(1, 32'h3F800000, 32'h3F800000);
      #1;
      checkOutput("bp_ready1", 32'(req_ready), 32'h2);
      step();
      req_valid[1] = 1'b0;
      step();
      applyStimulus(2, 32'h40400000, 32'h40400000);
      rsp_ready = 4'b1101;
      #1;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("bp%0d_rspvalid", i), 32'(rsp_valid), 32'h2);
         checkOutput($sformatf("bp%0d_result", i), rsp_result, 32'h3F800000);
         checkOutput($sformatf("bp%0d_ready", i), 32'(req_ready), 32'h0);
         step();
      end
      rsp_ready = 4'b1111;
      step();
      checkOutput("bp_after_ready", 32'(req_ready), 32'h4);
      checkOutput("bp_after_rspvalid", 32'(rsp_valid), 32'h0);
      step();
      req_valid[2] = 1'b0;
      step();
      checkOutput("bp_req2_rspvalid", 32'(rsp_valid), 32'h4);
      checkOutput("bp_req2_result", rsp_result, 32'h41100000);
      step();

      // Reset while EXEC discards the operation and restores index 0 priority.
      applyStimulus(3, 32'h40000000, 32'h40000000);
      #1;
      checkOutput("rx_ready3", 32'(req_ready), 32'h8);
      step();
      req_valid[3] = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rx%0d_no_rsp", i), 32'(rsp_valid), 32'h0);
         step();
      end
      applyStimulus(0, 32'h3F800000, 32'h40000000);
      applyStimulus(3, 32'h40000000, 32'h40000000);
      #1;
      checkOutput("rx_prio0", 32'(req_ready), 32'h1);
      step();
      req_valid[0] = 1'b0;
      step();
      checkOutput("rx_req0_rspvalid", 32'(rsp_valid), 32'h1);
      checkOutput("rx_req0_result", rsp_result, 32'h40000000);
      step();
      checkOutput("rx_next3", 32'(req_ready), 32'h8);
      step();
      req_valid[3] = 1'b0;
      step();
      checkOutput("rx_req3_rspvalid", 32'(rsp_valid), 32'h8);
      checkOutput("rx_req3_result", rsp_result, 32'h40800000);
      step();

`ifdef FP_MUL_ARB_CNT_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("cnt_rst_op", op_count, 32'h0);
      checkOutput("cnt_rst_exc", 32'(exc_count), 32'h0);
      runOp("cnt_a", 0, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
      runOp("cnt_b", 1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000);
      runOp("cnt_c", 2, 32'h3F800000, 32'hC0000000, 32'hC0000000, 3'b000);
      runOp("cnt_d", 3, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
      checkOutput("cnt_op", op_count, 32'd4);
      checkOutput("cnt_exc", 32'(exc_count), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("cnt_clr_op", op_count, 32'h0);
      checkOutput("cnt_clr_exc", 32'(exc_count), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
